nibble_bus_arbiter: RTL and testbench
=====================================

// Module: nibble_bus_arbiter
// PURPOSE
//   Shares the single external 4-bit data / 12-bit address nibble bus between NREQ on-chip
//   requesters (CPU core, debug/program loader, ...).
//   Arbitrates, then sequences each access as SETUP -> WAIT -> SAMPLE with programmable wait states.
//   Returns read data plus a one-cycle ack. Sits between requesters and the top-level uio/uo pad mapping.
// PARAMETERS
//   NREQ         2   number of requesters (>=1)
//   AW           12  address width
//   DW           4   data width
//   WAIT_CYCLES  1   bus wait states between SETUP and SAMPLE (0..15; 0 skips WAIT)
// PORTS
//   clk           in   1        single clock, rising edge
//   rst_n         in   1        reset, asynchronous, active-low
//   req           in   NREQ     per-requester access request (level)
//   we            in   NREQ     per-requester write enable (1=write, 0=read)
//   addr          in   NREQ*AW  packed per-requester address, slice i = [i*AW +: AW]
//   wdata         in   NREQ*DW  packed per-requester write data
//   gnt           out  NREQ     one-hot grant, held from SETUP through SAMPLE
//   ack           out  NREQ     one-cycle completion pulse, in SAMPLE
//   rdata         out  DW       captured bus data, valid while ack high, held afterwards
//   bus_addr      out  AW       external address
//   bus_data_out  out  DW       external write data
//   bus_data_in   in   DW       external read data
//   bus_data_rw   out  1        1 = drive bus (write, pad oe on); 0 = bus released/read
// BEHAVIOUR
//   - Reset: state IDLE; gnt=0, ack=0, rdata=0, bus_addr=0, bus_data_out=0, bus_data_rw=0;
//     RR pointer=0. Reset mid-transaction aborts immediately; no ack is issued.
//   - FSM: IDLE -> SETUP -> WAIT (WAIT_CYCLES cycles, skipped if 0) -> SAMPLE -> IDLE.
//   - IDLE: if any req, pick winner, register gnt, latch winner's addr/we/wdata, go SETUP.
//   - SETUP: bus_addr, bus_data_rw=we, bus_data_out=(we ? wdata : 0) driven from latched copies.
//     These are stable through SAMPLE.
//   - WAIT: down-counter loaded with WAIT_CYCLES; leave when it reaches 1.
//     Counter width is max(1,$clog2(WAIT_CYCLES+1)).
//   - SAMPLE: ack[winner]=1 for exactly this cycle. On a read, rdata <= bus_data_in.
//     On a write, rdata is unchanged. Next state IDLE.
//   - Latency: req sampled high in IDLE at cycle 0 -> ack at cycle 2+WAIT_CYCLES.
//     Back-to-back accesses by one requester therefore take 3+WAIT_CYCLES cycles.
//   - In IDLE: bus_data_rw=0 and bus_data_out=0; bus_addr holds the last value.
//   - Requester inputs are latched at grant. Changes to addr/we/wdata after grant are ignored.
//     Dropping req after grant does not abort; the transaction completes and ack still pulses.
//   - A req still high in the ack cycle counts as a new request at the next IDLE.
//   - Simultaneous reqs: exactly one winner per IDLE cycle; losers wait, no starvation under RR.
//   - gnt and ack are always one-hot or zero. At most one transaction is outstanding.
// CONFIGURATION
//   NIBBLE_BUS_ARB_RR_EN defined: round-robin. The search starts at (last winner+1) mod NREQ,
//     and the pointer updates on each grant.
//   Not defined: fixed priority, lowest index wins. The RR pointer is removed entirely.
//     Requester 0 can starve others.
// STRUCTURE
//   - Package nibble_bus_arb_pkg: state enum (IDLE, SETUP, WAIT, SAMPLE) and the width helper
//     localparams.
//   - Sub-module nibble_bus_rr_pick: combinational winner select (req, pointer -> one-hot, index).
//     It is also used in fixed-priority mode with pointer tied to 0.
// TESTING
//   1. Single read, W=1: req[0]=1, we=0, addr=12'hABC; bus_data_in=4'h5.
//      Expect bus_addr=ABC and rw=0 from cycle 1, ack[0] at cycle 3, rdata=5.
//   2. Single write, W=0: req[1], we=1, addr=12'h123, wdata=4'h9.
//      Expect rw=1 and data_out=9 in SETUP..SAMPLE, ack[1] at cycle 2, rw=0 the cycle after.
//   3. Contention: req=2'b11 held high.
//      RR_EN: acks alternate 0,1,0,1. Without RR_EN: only ack[0], repeated.
//   4. Input changes after grant: change addr to 12'h000 and drop req during WAIT.
//      Expect bus_addr stays at the original value and ack still pulses.
//   5. Reset during WAIT: assert rst_n=0 asynchronously.
//      Expect all outputs to go to 0 immediately, no ack, and IDLE after release.
//   6. W=15 sweep: ack exactly 17 cycles after the grant cycle.
//      Check gnt and ack stay one-hot throughout.

Source files
------------

// File: rtl/nibble_bus_arb_pkg.sv
// Shared types and width helpers for the nibble bus arbiter.
package nibble_bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, SAMPLE} arb_state_t;

  localparam int DEF_NREQ        = 2;
  localparam int DEF_WAIT_CYCLES = 1;

  // Width of a requester index; never below one bit so NREQ=1 still has a legal vector.
  function automatic int ptr_width(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

  // Width of the wait-state down-counter: max(1, clog2(w+1)).
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/nibble_bus_rr_pick.sv
// Combinational winner select: first requester at or after ptr, wrapping; one-hot plus index.
module nibble_bus_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx
);

  logic found;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    // Two passes: indices from ptr upward, then the wrapped range below ptr.
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found     = 1'b1;
        onehot[i] = 1'b1;
        idx       = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found     = 1'b1;
        onehot[i] = 1'b1;
        idx       = PW'(i);
      end
    end
  end

endmodule

// File: rtl/nibble_bus_arbiter.sv
// Arbitrates NREQ requesters onto the external nibble bus and runs SETUP -> WAIT -> SAMPLE.
// Fixed priority by default; define NIBBLE_BUS_ARB_RR_EN for round-robin arbitration.
module nibble_bus_arbiter
  import nibble_bus_arb_pkg::*;
#(
  parameter int NREQ        = DEF_NREQ,
  parameter int AW          = 12,
  parameter int DW          = 4,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      bus_addr,
  output logic [DW-1:0]      bus_data_out,
  input  logic [DW-1:0]      bus_data_in,
  output logic               bus_data_rw
);

  localparam int PW = ptr_width(NREQ);
  localparam int CW = cnt_width(WAIT_CYCLES);

  arb_state_t      state;
  logic [CW-1:0]   wait_cnt;
  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_we;
  logic            to_sample;

  nibble_bus_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
        sel_we    = we[i];
      end
    end
  end

  assign to_sample = ((state == SETUP) && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (wait_cnt == CW'(1)));

`ifdef NIBBLE_BUS_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if ((state == IDLE) && (|req)) begin
      rr_ptr <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
    end
  end
`else
  logic unused_idx;
  assign rr_ptr     = '0;
  assign unused_idx = ^pick_idx;
`endif

  // The bus outputs are the latched copies of the winner's request; bus_data_rw doubles as latched we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      gnt          <= '0;
      ack          <= '0;
      rdata        <= '0;
      bus_addr     <= '0;
      bus_data_out <= '0;
      bus_data_rw  <= 1'b0;
    end else begin
      ack <= '0;
      if (to_sample) begin
        // Capture on entry to SAMPLE so rdata is already valid while ack is high.
        state <= SAMPLE;
        ack   <= gnt;
        if (!bus_data_rw) rdata <= bus_data_in;
      end else begin
        case (state)
          IDLE: begin
            if (|req) begin
              state        <= SETUP;
              gnt          <= pick_oh;
              bus_addr     <= sel_addr;
              bus_data_rw  <= sel_we;
              bus_data_out <= sel_we ? sel_wdata : '0;
            end
          end
          SETUP: begin
            state    <= WAIT;
            wait_cnt <= CW'(WAIT_CYCLES);
          end
          WAIT: begin
            wait_cnt <= wait_cnt - CW'(1);
          end
          SAMPLE: begin
            state        <= IDLE;
            gnt          <= '0;
            bus_data_rw  <= 1'b0;
            bus_data_out <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nibble_bus_arbiter.sv
// Directed bench for nibble_bus_arbiter: W=1, W=0 and W=15 instances sharing the requester inputs.
module tb_nibble_bus_arbiter;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic [3:0]  rdata;
    logic [11:0] baddr;
    logic [3:0]  bdo;
    logic        rw;
  } out_t;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [3:0]  bdin;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [23:0] addr;
  logic [7:0]  wdata;
  logic [3:0]  bdin;

  logic [1:0]  gnt1, ack1, gnt0, ack0, gnt15, ack15;
  logic [3:0]  rdata1, rdata0, rdata15;
  logic [11:0] baddr1, baddr0, baddr15;
  logic [3:0]  bdo1, bdo0, bdo15;
  logic        brw1, brw0, brw15;
  out_t        o1, o0, o15;

  int vectors;
  int miscompares;

  nibble_bus_arbiter #(.NREQ(2), .AW(12), .DW(4), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt1), .ack(ack1), .rdata(rdata1), .bus_addr(baddr1),
    .bus_data_out(bdo1), .bus_data_in(bdin), .bus_data_rw(brw1));

  nibble_bus_arbiter #(.NREQ(2), .AW(12), .DW(4), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt0), .ack(ack0), .rdata(rdata0), .bus_addr(baddr0),
    .bus_data_out(bdo0), .bus_data_in(bdin), .bus_data_rw(brw0));

  nibble_bus_arbiter #(.NREQ(2), .AW(12), .DW(4), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt15), .ack(ack15), .rdata(rdata15), .bus_addr(baddr15),
    .bus_data_out(bdo15), .bus_data_in(bdin), .bus_data_rw(brw15));

  assign o1  = {gnt1, ack1, rdata1, baddr1, bdo1, brw1};
  assign o0  = {gnt0, ack0, rdata0, baddr0, bdo0, brw0};
  assign o15 = {gnt15, ack15, rdata15, baddr15, bdo15, brw15};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w, input logic [23:0] a,
                              input logic [7:0] wd, input logic [3:0] bd,
                              input logic [1:0] g, input logic [1:0] ak, input logic [3:0] rd,
                              input logic [11:0] ba, input logic [3:0] d, input logic rw);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = wd; v.bdin = bd;
    v.exp = {g, ak, rd, ba, d, rw};
    return v;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got gnt=%b ack=%b rdata=%h addr=%h dout=%h rw=%b, want gnt=%b ack=%b rdata=%h addr=%h dout=%h rw=%b",
               name, act.gnt, act.ack, act.rdata, act.baddr, act.bdo, act.rw,
               exp.gnt, exp.ack, exp.rdata, exp.baddr, exp.bdo, exp.rw);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [23:0] a,
                       input logic [7:0] wd, input logic [3:0] bd);
    req = r; we = w; addr = a; wdata = wd; bdin = bd;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 24'h0, 8'h0, 4'h0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t tbl[12];
  int   winners[$];
  int   ack_at;
  int   ack_len;
  int   onehot_bad;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    drive(2'b00, 2'b00, 24'h0, 8'h0, 4'h0);

    //              req    we     addr        wdata  bdin   gnt    ack    rd    baddr    dout  rw
    tbl[0]  = mk(2'b01, 2'b00, 24'h000ABC, 8'h00, 4'h5, 2'b01, 2'b00, 4'h0, 12'hABC, 4'h0, 1'b0);
    tbl[1]  = mk(2'b00, 2'b00, 24'h000ABC, 8'h00, 4'h5, 2'b01, 2'b00, 4'h0, 12'hABC, 4'h0, 1'b0);
    tbl[2]  = mk(2'b00, 2'b00, 24'h000ABC, 8'h00, 4'h5, 2'b01, 2'b01, 4'h5, 12'hABC, 4'h0, 1'b0);
    tbl[3]  = mk(2'b00, 2'b00, 24'h000ABC, 8'h00, 4'h5, 2'b00, 2'b00, 4'h5, 12'hABC, 4'h0, 1'b0);
    tbl[4]  = mk(2'b10, 2'b10, 24'h123ABC, 8'h90, 4'h5, 2'b10, 2'b00, 4'h5, 12'h123, 4'h9, 1'b1);
    tbl[5]  = mk(2'b00, 2'b00, 24'h000000, 8'h00, 4'h7, 2'b10, 2'b00, 4'h5, 12'h123, 4'h9, 1'b1);
    tbl[6]  = mk(2'b00, 2'b00, 24'h000000, 8'h00, 4'h7, 2'b10, 2'b10, 4'h5, 12'h123, 4'h9, 1'b1);
    tbl[7]  = mk(2'b00, 2'b00, 24'h000000, 8'h00, 4'h7, 2'b00, 2'b00, 4'h5, 12'h123, 4'h0, 1'b0);
    tbl[8]  = mk(2'b11, 2'b00, 24'h789456, 8'h00, 4'hA, 2'b01, 2'b00, 4'h5, 12'h456, 4'h0, 1'b0);
    tbl[9]  = mk(2'b11, 2'b00, 24'h789456, 8'h00, 4'hA, 2'b01, 2'b00, 4'h5, 12'h456, 4'h0, 1'b0);
    tbl[10] = mk(2'b11, 2'b00, 24'h789456, 8'h00, 4'hA, 2'b01, 2'b01, 4'hA, 12'h456, 4'h0, 1'b0);
    tbl[11] = mk(2'b00, 2'b00, 24'h789456, 8'h00, 4'hA, 2'b00, 2'b00, 4'hA, 12'h456, 4'h0, 1'b0);

    // Reset state of every instance.
    drive(2'b00, 2'b00, 24'h0, 8'h0, 4'h0);
    rst_n = 1'b0;
    tick();
    check_out("reset_w1", o1, '0);
    check_out("reset_w0", o0, '0);
    check_out("reset_w15", o15, '0);
    tick();
    rst_n = 1'b1;

    // Read, write with post-grant input changes, then contention that both modes resolve to 0.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].bdin);
      tick();
      check_out($sformatf("tbl[%0d]", i), o1, tbl[i].exp);
    end

    // Write with zero wait states: SETUP, SAMPLE (ack), then bus released.
    do_reset();
    drive(2'b10, 2'b10, 24'h123000, 8'h90, 4'h0);
    tick();
    drive(2'b00, 2'b00, 24'h0, 8'h0, 4'h0);
    check_out("w0_setup", o0, {2'b10, 2'b00, 4'h0, 12'h123, 4'h9, 1'b1});
    tick();
    check_out("w0_sample", o0, {2'b10, 2'b10, 4'h0, 12'h123, 4'h9, 1'b1});
    tick();
    check_out("w0_idle", o0, {2'b00, 2'b00, 4'h0, 12'h123, 4'h0, 1'b0});

    // Contention with both requests held: four transactions in 16 cycles at W=1.
    do_reset();
    drive(2'b11, 2'b00, 24'h222111, 8'h00, 4'h4);
    winners.delete();
    for (int c = 0; c < 16; c++) begin
      tick();
      if (ack1 == 2'b01) winners.push_back(0);
      else if (ack1 == 2'b10) winners.push_back(1);
      else if (ack1 != 2'b00) winners.push_back(9);
    end
    drive(2'b00, 2'b00, 24'h0, 8'h0, 4'h0);
    check_int("contention_ack_count", winners.size(), 4);
    for (int k = 0; k < 4; k++) begin
`ifdef NIBBLE_BUS_ARB_RR_EN
      check_int($sformatf("contention_winner[%0d]", k),
                (k < winners.size()) ? winners[k] : -1, k % 2);
`else
      check_int($sformatf("contention_winner[%0d]", k),
                (k < winners.size()) ? winners[k] : -1, 0);
`endif
    end

    // Address change and req drop during WAIT are ignored; ack still pulses.
    do_reset();
    drive(2'b01, 2'b00, 24'h000DEF, 8'h00, 4'hC);
    tick();
    tick();
    drive(2'b00, 2'b00, 24'h000000, 8'h00, 4'hC);
    check_out("late_change_wait", o1, {2'b01, 2'b00, 4'h0, 12'hDEF, 4'h0, 1'b0});
    tick();
    check_out("late_change_ack", o1, {2'b01, 2'b01, 4'hC, 12'hDEF, 4'h0, 1'b0});

    // Asynchronous reset in the middle of a WAIT state aborts without an ack.
    do_reset();
    drive(2'b01, 2'b01, 24'h000321, 8'h06, 4'h0);
    tick();
    drive(2'b00, 2'b00, 24'h0, 8'h0, 4'h0);
    tick();
    check_out("pre_abort_wait", o1, {2'b01, 2'b00, 4'h0, 12'h321, 4'h6, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check_out("abort_immediate", o1, '0);
    tick();
    check_out("abort_held", o1, '0);
    rst_n = 1'b1;
    tick();
    check_out("abort_no_ack_1", o1, '0);
    tick();
    check_out("abort_no_ack_2", o1, '0);
    drive(2'b01, 2'b00, 24'h000555, 8'h00, 4'h0);
    tick();
    drive(2'b00, 2'b00, 24'h0, 8'h0, 4'h0);
    check_out("abort_idle_regrant", o1, {2'b01, 2'b00, 4'h0, 12'h555, 4'h0, 1'b0});

    // Fifteen wait states: ack exactly 17 cycles after the request is sampled, one cycle wide.
    do_reset();
    drive(2'b01, 2'b00, 24'h0000F0, 8'h00, 4'h3);
    ack_at     = -1;
    ack_len    = 0;
    onehot_bad = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 1) drive(2'b00, 2'b00, 24'h0, 8'h0, 4'h3);
      if (!$onehot0(gnt15) || !$onehot0(ack15)) onehot_bad++;
      if (ack15 != 2'b00) begin
        if (ack_at < 0) ack_at = e;
        ack_len++;
      end
    end
    check_int("w15_ack_cycle", ack_at, 17);
    check_int("w15_ack_width", ack_len, 1);
    check_int("w15_onehot_violations", onehot_bad, 0);
    check_int("w15_rdata", int'(rdata15), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
